// File: rtl/blk_26af77.sv
// blk_26af77: throttled AXI write drainer (TOP AW/W buffered, BUS AW issued only once its burst data is buffered, B passed through; clk/reset/clk_en, TOP and BUS AW/W/B channels; WR_THROTTLE_STATS_EN adds stall_cnt)
module blk_26af77 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int MAXREQS = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
`ifdef WR_THROTTLE_STATS_EN
  output logic [31:0]             stall_cnt,
`endif
  input  logic [ADDR_WIDTH-1:0]   in_TOP_AWADDR,
  input  logic [7:0]              in_TOP_AWLEN,
  input  logic                    in_TOP_AWVALID,
  output logic                    out_TOP_AWREADY,
  input  logic [DATA_WIDTH-1:0]   in_TOP_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_TOP_WSTRB,
  input  logic                    in_TOP_WLAST,
  input  logic                    in_TOP_WVALID,
  output logic                    out_TOP_WREADY,
  output logic                    out_TOP_BVALID,
  input  logic                    in_TOP_BREADY,
  output logic [ADDR_WIDTH-1:0]   out_BUS_AWADDR,
  output logic [7:0]              out_BUS_AWLEN,
  output logic                    out_BUS_AWVALID,
  input  logic                    in_BUS_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_BUS_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_BUS_WSTRB,
  output logic                    out_BUS_WLAST,
  output logic                    out_BUS_WVALID,
  input  logic                    in_BUS_WREADY,
  input  logic                    in_BUS_BVALID,
  output logic                    out_BUS_BREADY
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AP = $clog2(MAXREQS);
  localparam int WP = $clog2(DEPTH);
  localparam int CW = $clog2(256 + DEPTH + 1);
  localparam int WW = DATA_WIDTH + SW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WP:0] DEPTH_W = (WP+1)'(DEPTH);
  localparam logic [7:0] MAX_C = 8'(MAX_OUTSTANDING);
  logic [ADDR_WIDTH+7:0] aw_mem [MAXREQS];
  logic [WW-1:0] w_mem [DEPTH];
  logic [AP:0] aw_wp, aw_rp;
  logic [WP:0] w_wp, w_rp, wcnt;
  logic hd_valid, sl_valid;
  logic [ADDR_WIDTH-1:0] hd_addr, sl_addr;
  logic [7:0] hd_len, sl_len, outst;
  logic [CW-1:0] ccnt, wcnt_c, uncom, need;
  logic aw_full, aw_empty, aw_push, hd_load, w_push, w_pop, issue_ok, issue, b_hs;
  logic [WW-1:0] w_head;
  always_comb begin
    aw_full = (aw_wp ^ aw_rp) == {1'b1, {AP{1'b0}}};
    aw_empty = aw_wp == aw_rp;
    wcnt = w_wp - w_rp;
    wcnt_c = CW'(wcnt);
    need = CW'(hd_len) + CW'(1);
    uncom = wcnt_c > ccnt ? wcnt_c - ccnt : '0;
    issue_ok = hd_valid && outst < MAX_C && (!sl_valid || in_BUS_AWREADY) &&
               (uncom >= need || (need > DEPTH_C && wcnt_c == DEPTH_C));
    issue = clk_en && issue_ok;
    aw_push = clk_en && in_TOP_AWVALID && !aw_full;
    hd_load = clk_en && !aw_empty && (!hd_valid || issue);
    w_push = clk_en && in_TOP_WVALID && wcnt != DEPTH_W;
    w_head = w_mem[w_rp[WP-1:0]];
    w_pop = clk_en && out_BUS_WVALID && in_BUS_WREADY;
    b_hs = clk_en && in_BUS_BVALID && in_TOP_BREADY;
  end
  assign out_TOP_AWREADY = !aw_full;
  assign out_TOP_WREADY = wcnt != DEPTH_W;
  assign out_TOP_BVALID = in_BUS_BVALID;
  assign out_BUS_BREADY = in_TOP_BREADY;
  assign out_BUS_AWVALID = sl_valid;
  assign out_BUS_AWADDR = sl_addr;
  assign out_BUS_AWLEN = sl_len;
  assign out_BUS_WVALID = wcnt != '0 && ccnt != '0;
  assign {out_BUS_WLAST, out_BUS_WSTRB, out_BUS_WDATA} = w_head;
  always_ff @(posedge clk) begin
    if (aw_push) aw_mem[aw_wp[AP-1:0]] <= {in_TOP_AWADDR, in_TOP_AWLEN};
    if (w_push) w_mem[w_wp[WP-1:0]] <= {in_TOP_WLAST, in_TOP_WSTRB, in_TOP_WDATA};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_wp <= '0;
      aw_rp <= '0;
      w_wp <= '0;
      w_rp <= '0;
      hd_valid <= 1'b0;
      hd_addr <= '0;
      hd_len <= '0;
      sl_valid <= 1'b0;
      sl_addr <= '0;
      sl_len <= '0;
      ccnt <= '0;
      outst <= '0;
    end else begin
      if (aw_push) aw_wp <= aw_wp + (AP+1)'(1);
      if (hd_load) begin
        {hd_addr, hd_len} <= aw_mem[aw_rp[AP-1:0]];
        aw_rp <= aw_rp + (AP+1)'(1);
      end
      if (hd_load) hd_valid <= 1'b1;
      else if (issue) hd_valid <= 1'b0;
      if (w_push) w_wp <= w_wp + (WP+1)'(1);
      if (w_pop) w_rp <= w_rp + (WP+1)'(1);
      if (issue) begin
        sl_valid <= 1'b1;
        sl_addr <= hd_addr;
        sl_len <= hd_len;
      end else if (clk_en && in_BUS_AWREADY) sl_valid <= 1'b0;
      if (clk_en) begin
        ccnt <= ccnt + (issue ? need : '0) - (w_pop ? CW'(1) : '0);
        outst <= outst + 8'(issue) - 8'(b_hs && outst != '0);
      end
    end
  end
`ifdef WR_THROTTLE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (clk_en && hd_valid && !issue_ok && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_blk_26af77.sv
// tb_blk_26af77: directed self-checking bench for blk_26af77
module tb_blk_26af77;
  logic clk, reset, clk_en;
  logic [31:0] in_TOP_AWADDR, out_BUS_AWADDR, in_TOP_WDATA, out_BUS_WDATA;
  logic [7:0] in_TOP_AWLEN, out_BUS_AWLEN;
  logic [3:0] in_TOP_WSTRB, out_BUS_WSTRB;
  logic in_TOP_AWVALID, out_TOP_AWREADY, in_TOP_WLAST, in_TOP_WVALID, out_TOP_WREADY;
  logic out_TOP_BVALID, in_TOP_BREADY, out_BUS_AWVALID, in_BUS_AWREADY;
  logic out_BUS_WLAST, out_BUS_WVALID, in_BUS_WREADY, in_BUS_BVALID, out_BUS_BREADY;
`ifdef WR_THROTTLE_STATS_EN
  logic [31:0] stall_cnt, s0;
`endif
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int lasts = 0;
  int p0, l0, n;

  blk_26af77 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .MAXREQS(16), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
`ifdef WR_THROTTLE_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .in_TOP_AWADDR(in_TOP_AWADDR), .in_TOP_AWLEN(in_TOP_AWLEN), .in_TOP_AWVALID(in_TOP_AWVALID),
    .out_TOP_AWREADY(out_TOP_AWREADY), .in_TOP_WDATA(in_TOP_WDATA), .in_TOP_WSTRB(in_TOP_WSTRB),
    .in_TOP_WLAST(in_TOP_WLAST), .in_TOP_WVALID(in_TOP_WVALID), .out_TOP_WREADY(out_TOP_WREADY),
    .out_TOP_BVALID(out_TOP_BVALID), .in_TOP_BREADY(in_TOP_BREADY),
    .out_BUS_AWADDR(out_BUS_AWADDR), .out_BUS_AWLEN(out_BUS_AWLEN), .out_BUS_AWVALID(out_BUS_AWVALID),
    .in_BUS_AWREADY(in_BUS_AWREADY), .out_BUS_WDATA(out_BUS_WDATA), .out_BUS_WSTRB(out_BUS_WSTRB),
    .out_BUS_WLAST(out_BUS_WLAST), .out_BUS_WVALID(out_BUS_WVALID), .in_BUS_WREADY(in_BUS_WREADY),
    .in_BUS_BVALID(in_BUS_BVALID), .out_BUS_BREADY(out_BUS_BREADY)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && clk_en && out_BUS_WVALID && in_BUS_WREADY) begin
      pops <= pops + 1;
      if (out_BUS_WLAST) lasts <= lasts + 1;
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] d, input logic l);
    int k;
    k = 0;
    in_TOP_WDATA = d;
    in_TOP_WSTRB = 4'hF;
    in_TOP_WLAST = l;
    in_TOP_WVALID = 1;
    while (!out_TOP_WREADY && k < 50) begin
      step;
      k++;
    end
    chk("w_accept_timeout", 64'(k == 50), 0);
    step;
    in_TOP_WVALID = 0;
  endtask

  task automatic push_aw(input logic [31:0] a, input logic [7:0] len);
    in_TOP_AWADDR = a;
    in_TOP_AWLEN = len;
    in_TOP_AWVALID = 1;
    step;
    in_TOP_AWVALID = 0;
  endtask

  task automatic b_hs;
    in_BUS_BVALID = 1;
    step;
    in_BUS_BVALID = 0;
  endtask

  initial begin
    reset = 1; clk_en = 1;
    in_TOP_AWADDR = 0; in_TOP_AWLEN = 0; in_TOP_AWVALID = 0;
    in_TOP_WDATA = 0; in_TOP_WSTRB = 0; in_TOP_WLAST = 0; in_TOP_WVALID = 0;
    in_TOP_BREADY = 1; in_BUS_AWREADY = 1; in_BUS_WREADY = 1; in_BUS_BVALID = 0;
    step; step;
    chk("rst_awvalid", out_BUS_AWVALID, 0);
    chk("rst_wvalid", out_BUS_WVALID, 0);
    chk("rst_awready", out_TOP_AWREADY, 1);
    chk("rst_wready", out_TOP_WREADY, 1);
    reset = 0;
    step;
    chk("post_rst_awvalid", out_BUS_AWVALID, 0);

    // basic burst: 4 beats buffered, then AWLEN=3
    for (int i = 0; i < 4; i++) push_w(32'hA0 + i, i == 3);
    chk("b1_wvalid_uncommitted", out_BUS_WVALID, 0);
    push_aw(32'h1000, 3);
    chk("b1_aw_n", out_BUS_AWVALID, 0);
    step;
    chk("b1_aw_n1", out_BUS_AWVALID, 0);
    step;
    chk("b1_aw_n2", out_BUS_AWVALID, 1);
    chk("b1_awaddr", out_BUS_AWADDR, 32'h1000);
    chk("b1_awlen", out_BUS_AWLEN, 3);
    for (int i = 0; i < 4; i++) begin
      chk("b1_wvalid", out_BUS_WVALID, 1);
      chk("b1_wdata", out_BUS_WDATA, 32'hA0 + i);
      chk("b1_wlast", out_BUS_WLAST, i == 3);
      step;
    end
    chk("b1_wvalid_done", out_BUS_WVALID, 0);
    chk("b1_aw_done", out_BUS_AWVALID, 0);
    in_BUS_BVALID = 1;
    #1;
    chk("b_pass", out_TOP_BVALID, 1);
    step;
    in_BUS_BVALID = 0;

    // AWLEN=7 waits for all 8 beats
    p0 = pops; l0 = lasts;
    push_aw(32'h2000, 7);
    for (int i = 0; i < 5; i++) push_w(32'hB0 + i, 0);
    step; step;
    chk("b2_wait5", out_BUS_AWVALID, 0);
    push_w(32'hB5, 0);
    chk("b2_wait6", out_BUS_AWVALID, 0);
    push_w(32'hB6, 0);
    chk("b2_wait7", out_BUS_AWVALID, 0);
    push_w(32'hB7, 1);
    chk("b2_wait8", out_BUS_AWVALID, 0);
    step;
    chk("b2_issue", out_BUS_AWVALID, 1);
    chk("b2_awlen", out_BUS_AWLEN, 7);
    for (int i = 0; i < 8; i++) step;
    chk("b2_pops", pops - p0, 8);
    chk("b2_lasts", lasts - l0, 1);
    chk("b2_wvalid_done", out_BUS_WVALID, 0);
    b_hs;

    // outstanding limit of 2
    p0 = pops;
    for (int i = 0; i < 3; i++) push_w(32'hC0 + i, 1);
    in_TOP_AWLEN = 0; in_TOP_AWVALID = 1;
    in_TOP_AWADDR = 32'h3000;
    step;
    chk("mo_a0", out_BUS_AWVALID, 0);
    in_TOP_AWADDR = 32'h3100;
    step;
    chk("mo_a1", out_BUS_AWVALID, 0);
    in_TOP_AWADDR = 32'h3200;
    step;
    in_TOP_AWVALID = 0;
    chk("mo_a2", out_BUS_AWVALID, 1);
    chk("mo_addr1", out_BUS_AWADDR, 32'h3000);
    step;
    chk("mo_a3", out_BUS_AWVALID, 1);
    chk("mo_addr2", out_BUS_AWADDR, 32'h3100);
    step;
    chk("mo_block0", out_BUS_AWVALID, 0);
    step; step;
    chk("mo_block1", out_BUS_AWVALID, 0);
    b_hs;
    chk("mo_bedge", out_BUS_AWVALID, 0);
    step;
    chk("mo_third", out_BUS_AWVALID, 1);
    chk("mo_addr3", out_BUS_AWADDR, 32'h3200);
    step;
    chk("mo_third_done", out_BUS_AWVALID, 0);
    chk("mo_pops", pops - p0, 3);
    b_hs; b_hs;

    // AWLEN=31 larger than data FIFO
    p0 = pops; l0 = lasts;
    push_aw(32'h4000, 31);
    for (int i = 0; i < 16; i++) push_w(32'hD00 + i, 0);
    chk("big_wait", out_BUS_AWVALID, 0);
    step;
    chk("big_issue", out_BUS_AWVALID, 1);
    chk("big_awlen", out_BUS_AWLEN, 31);
    for (int i = 16; i < 32; i++) push_w(32'hD00 + i, i == 31);
    n = 0;
    while (out_BUS_WVALID && n < 60) begin
      step;
      n++;
    end
    chk("big_drain_timeout", 64'(n == 60), 0);
    chk("big_pops", pops - p0, 32);
    chk("big_lasts", lasts - l0, 1);
    chk("big_wvalid_done", out_BUS_WVALID, 0);
    b_hs;

    // reset during beat 2 of 4
    for (int i = 0; i < 4; i++) push_w(32'hE0 + i, i == 3);
    push_aw(32'h5000, 3);
    step; step;
    chk("mr_issue", out_BUS_AWVALID, 1);
    step;
    chk("mr_beat2", out_BUS_WDATA, 32'hE1);
    reset = 1;
    #1;
    chk("mr_awvalid", out_BUS_AWVALID, 0);
    chk("mr_wvalid", out_BUS_WVALID, 0);
    chk("mr_awready", out_TOP_AWREADY, 1);
    chk("mr_wready", out_TOP_WREADY, 1);
    step;
    reset = 0;
    step;
    push_w(32'hF0, 1);
    push_aw(32'h6000, 0);
    step; step;
    chk("mr_new_aw", out_BUS_AWVALID, 1);
    chk("mr_new_addr", out_BUS_AWADDR, 32'h6000);
    chk("mr_new_wvalid", out_BUS_WVALID, 1);
    chk("mr_new_wdata", out_BUS_WDATA, 32'hF0);
    chk("mr_new_wlast", out_BUS_WLAST, 1);
    step;
    chk("mr_new_done", out_BUS_WVALID, 0);
    b_hs;

    // clk_en freeze, slice hold under AWREADY low, B/BREADY passthrough
    clk_en = 0;
    in_BUS_AWREADY = 0;
    in_TOP_WDATA = 32'h77; in_TOP_WSTRB = 4'h3; in_TOP_WLAST = 1; in_TOP_WVALID = 1;
    in_TOP_AWADDR = 32'h7000; in_TOP_AWLEN = 0; in_TOP_AWVALID = 1;
    step; step; step;
    chk("ce_awvalid", out_BUS_AWVALID, 0);
    chk("ce_wvalid", out_BUS_WVALID, 0);
    in_BUS_BVALID = 1;
    in_TOP_BREADY = 0;
    #1;
    chk("ce_bvalid_pass", out_TOP_BVALID, 1);
    chk("ce_bready_pass", out_BUS_BREADY, 0);
    in_BUS_BVALID = 0;
    in_TOP_BREADY = 1;
    clk_en = 1;
    step;
    in_TOP_WVALID = 0; in_TOP_AWVALID = 0;
    chk("ce_e0", out_BUS_AWVALID, 0);
    step;
    chk("ce_e1", out_BUS_AWVALID, 0);
    step;
    chk("ce_e2", out_BUS_AWVALID, 1);
    chk("ce_wstrb", out_BUS_WSTRB, 4'h3);
    step;
    chk("ce_hold_v", out_BUS_AWVALID, 1);
    chk("ce_hold_addr", out_BUS_AWADDR, 32'h7000);
    in_BUS_AWREADY = 1;
    step;
    chk("ce_released", out_BUS_AWVALID, 0);
    b_hs;

`ifdef WR_THROTTLE_STATS_EN
    push_aw(32'h8000, 0);
    step;
    s0 = stall_cnt;
    for (int i = 0; i < 10; i++) step;
    chk("stall_cnt", stall_cnt - s0, 10);
    push_w(32'h88, 1);
    step; step; step;
    b_hs;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
